// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared Gray/binary helpers and sizing for the async FIFO pointer handlers
package fifo_pkg;

  // Widest pointer supported (PTR_WIDTH up to 12, plus the wrap bit).
  localparam int MAX_W = 13;

  function automatic int unsigned fifo_depth(input int unsigned ptr_width);
    return 32'd1 << ptr_width;
  endfunction

  // Callers zero-extend narrower pointers to MAX_W; the zero MSBs leave both codes unchanged.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
    logic [MAX_W-1:0] bin;
    for (int i = 0; i < MAX_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// rtl/gray2bin_conv.sv - combinational Gray-to-binary converter, XOR prefix chain from the MSB
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/wptr_handler_ext.sv
// rtl/wptr_handler_ext.sv - write-domain pointer controller: pointers, full, almost-full, level, overflow
module wptr_handler_ext
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = 3
) (
  input  logic                 wclk,
  input  logic                 w_rst,
  input  logic                 wen,
  input  logic [PTR_WIDTH:0]   g_rptr_sync,
  input  logic [PTR_WIDTH:0]   af_thresh,
  input  logic                 ovf_clr,
  output logic                 w_accept,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wlevel,
  output logic                 overflow
);

  logic [PTR_WIDTH:0] b_next;
  logic [PTR_WIDTH:0] g_next;
  logic [PTR_WIDTH:0] rbin;
  logic [PTR_WIDTH:0] level_next;
  logic               full_next;

  gray2bin_conv #(
    .WIDTH(PTR_WIDTH + 1)
  ) u_rptr_conv (
    .gray(g_rptr_sync),
    .bin (rbin)
  );

  assign w_accept = wen & ~full;
  assign waddr    = b_wptr[PTR_WIDTH-1:0];
  assign b_next   = b_wptr + {{PTR_WIDTH{1'b0}}, w_accept};
  assign g_next   = b_next ^ (b_next >> 1);

  // Full when the write pointer is exactly one lap ahead: in Gray code that is the top two bits inverted.
  assign full_next  = (g_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]});
  assign level_next = b_next - rbin;

  always_ff @(posedge wclk) begin
    if (w_rst) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
    end else begin
      b_wptr      <= b_next;
      g_wptr      <= g_next;
      full        <= full_next;
      almost_full <= (level_next >= af_thresh);
      wlevel      <= level_next;
      // A rejected write sets the flag even if a clear is requested in the same cycle.
      if (wen && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_handler_ext.sv
// tb/tb_wptr_handler_ext.sv - self-checking bench for wptr_handler_ext with a counting reference model
module tb_wptr_handler_ext;

  localparam int PW    = 3;
  localparam int DEPTH = 8;

  logic        wclk = 1'b0;
  logic        w_rst = 1'b1;
  logic        wen = 1'b0;
  logic [3:0]  g_rptr_sync = '0;
  logic [3:0]  af_thresh = 4'd6;
  logic        ovf_clr = 1'b0;
  logic        w_accept;
  logic [2:0]  waddr;
  logic [3:0]  b_wptr;
  logic [3:0]  g_wptr;
  logic        full;
  logic        almost_full;
  logic [3:0]  wlevel;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: total words written and read, as unbounded counts.
  int wcount, rcount;
  bit m_full, m_af, m_ovf, exp_acc, got_acc;
  int m_level;

  wptr_handler_ext #(.PTR_WIDTH(PW)) dut (
    .wclk(wclk), .w_rst(w_rst), .wen(wen), .g_rptr_sync(g_rptr_sync),
    .af_thresh(af_thresh), .ovf_clr(ovf_clr), .w_accept(w_accept), .waddr(waddr),
    .b_wptr(b_wptr), .g_wptr(g_wptr), .full(full), .almost_full(almost_full),
    .wlevel(wlevel), .overflow(overflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [3:0] to_gray(input int v);
    logic [3:0] b;
    b = 4'(v % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset(input int n);
    @(negedge wclk);
    w_rst = 1'b1; wen = 1'b1; ovf_clr = 1'b0;
    repeat (n) @(posedge wclk);
    #1;
    @(negedge wclk);
    w_rst = 1'b0; wen = 1'b0;
    wcount = 0; rcount = 0; m_level = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
    g_rptr_sync = to_gray(0);
  endtask

  // One clock: drive at the falling edge, advance the model, sample 1 ns after the rising edge.
  task automatic cycle(input bit w, input bit c);
    @(negedge wclk);
    wen = w; ovf_clr = c;
    g_rptr_sync = to_gray(rcount);
    #1;
    got_acc = w_accept;
    exp_acc = w && !m_full;
    if (w && m_full) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (exp_acc) wcount++;
    m_level = ((wcount - rcount) % 16 + 16) % 16;
    m_full  = (m_level == DEPTH);
    m_af    = (m_level >= int'(af_thresh));
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks++; if (b_wptr !== 4'd0)    begin n_fail++; $display("FAIL reset_b_wptr got %0d want 0", b_wptr); end
    n_checks++; if (g_wptr !== 4'd0)    begin n_fail++; $display("FAIL reset_g_wptr got %0d want 0", g_wptr); end
    n_checks++; if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full got %0b want 0", full); end
    n_checks++; if (wlevel !== 4'd0)    begin n_fail++; $display("FAIL reset_wlevel got %0d want 0", wlevel); end
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %0b want 0", almost_full); end
  endtask

  task automatic test_fill();
    af_thresh = 4'd6;
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 0);
      n_checks++; if (wlevel !== 4'(i)) begin n_fail++; $display("FAIL fill_level[%0d] got %0d want %0d", i, wlevel, i); end
      n_checks++; if (almost_full !== (i >= 6)) begin n_fail++; $display("FAIL fill_af[%0d] got %0b want %0b", i, almost_full, i >= 6); end
      n_checks++; if (full !== (i == 8)) begin n_fail++; $display("FAIL fill_full[%0d] got %0b want %0b", i, full, i == 8); end
    end
    n_checks++; if (b_wptr !== 4'b1000) begin n_fail++; $display("FAIL fill_b_wptr got %b want 1000", b_wptr); end
    n_checks++; if (g_wptr !== 4'b1100) begin n_fail++; $display("FAIL fill_g_wptr got %b want 1100", g_wptr); end
    n_checks++; if (waddr !== 3'd0)     begin n_fail++; $display("FAIL fill_waddr got %0d want 0", waddr); end
  endtask

  task automatic test_overflow();
    cycle(1, 0);
    n_checks++; if (got_acc !== 1'b0)   begin n_fail++; $display("FAIL ovf_accept got %0b want 0", got_acc); end
    n_checks++; if (b_wptr !== 4'd8)    begin n_fail++; $display("FAIL ovf_b_hold got %0d want 8", b_wptr); end
    n_checks++; if (overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_set got %0b want 1", overflow); end
    cycle(1, 1);
    n_checks++; if (overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_set_wins got %0b want 1", overflow); end
    cycle(0, 1);
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL ovf_clear got %0b want 0", overflow); end
  endtask

  task automatic test_release();
    rcount = 3;
    cycle(0, 0);
    n_checks++; if (g_rptr_sync !== 4'b0010) begin n_fail++; $display("FAIL rel_rptr_drive got %b want 0010", g_rptr_sync); end
    n_checks++; if (full !== 1'b0)        begin n_fail++; $display("FAIL rel_full got %0b want 0", full); end
    n_checks++; if (wlevel !== 4'd5)      begin n_fail++; $display("FAIL rel_level got %0d want 5", wlevel); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL rel_af got %0b want 0", almost_full); end
  endtask

  task automatic test_wrap();
    logic [3:0] prev_g;
    do_reset(1);
    prev_g = g_wptr;
    for (int i = 1; i <= 20; i++) begin
      rcount = (wcount >= 2) ? wcount - 2 : 0;
      cycle(1, 0);
      n_checks++; if (b_wptr !== 4'(i % 16)) begin n_fail++; $display("FAIL wrap_b[%0d] got %0d want %0d", i, b_wptr, i % 16); end
      n_checks++; if (g_wptr !== to_gray(i)) begin n_fail++; $display("FAIL wrap_g[%0d] got %b want %b", i, g_wptr, to_gray(i)); end
      n_checks++; if ($countones(g_wptr ^ prev_g) != 1) begin n_fail++; $display("FAIL wrap_gray_step[%0d] got %0d bits want 1", i, $countones(g_wptr ^ prev_g)); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_full[%0d] got %0b want 0", i, full); end
      prev_g = g_wptr;
    end
  endtask

  task automatic test_thresholds();
    af_thresh = 4'd0;
    do_reset(1);
    cycle(0, 0);
    n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL thr0_af got %0b want 1", almost_full); end
    n_checks++; if (wlevel !== 4'd0)      begin n_fail++; $display("FAIL thr0_level got %0d want 0", wlevel); end
    af_thresh = 4'd9;
    for (int i = 0; i < 8; i++) cycle(1, 0);
    n_checks++; if (full !== 1'b1)        begin n_fail++; $display("FAIL thr9_full got %0b want 1", full); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL thr9_af got %0b want 0", almost_full); end
  endtask

  task automatic test_random();
    af_thresh = 4'($urandom_range(0, 9));
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        af_thresh = 4'($urandom_range(0, 9));
        do_reset(1);
      end
      // Reader advances by 0..2 words but never past what has been written.
      rcount = rcount + $urandom_range(0, 2);
      if (rcount > wcount) rcount = wcount;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      n_checks++; if (got_acc !== exp_acc)  begin n_fail++; $display("FAIL rnd_accept[%0d] got %0b want %0b", i, got_acc, exp_acc); end
      n_checks++; if (b_wptr !== 4'(wcount % 16)) begin n_fail++; $display("FAIL rnd_b[%0d] got %0d want %0d", i, b_wptr, wcount % 16); end
      n_checks++; if (g_wptr !== to_gray(wcount)) begin n_fail++; $display("FAIL rnd_g[%0d] got %b want %b", i, g_wptr, to_gray(wcount)); end
      n_checks++; if (waddr !== 3'(wcount % 8)) begin n_fail++; $display("FAIL rnd_waddr[%0d] got %0d want %0d", i, waddr, wcount % 8); end
      n_checks++; if (wlevel !== 4'(m_level)) begin n_fail++; $display("FAIL rnd_level[%0d] got %0d want %0d", i, wlevel, m_level); end
      n_checks++; if (full !== m_full)      begin n_fail++; $display("FAIL rnd_full[%0d] got %0b want %0b", i, full, m_full); end
      n_checks++; if (almost_full !== m_af) begin n_fail++; $display("FAIL rnd_af[%0d] got %0b want %0b", i, almost_full, m_af); end
      n_checks++; if (overflow !== m_ovf)   begin n_fail++; $display("FAIL rnd_ovf[%0d] got %0b want %0b", i, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_thresholds();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
